pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
Receive-side counterpart of the periodic pulse generator. It measures the spacing between single-cycle strobes on pulse_in and reports the period in the generator's "ticks" convention, where ticks = T gives one pulse every T+1 clocks. A generator-to-meter loopback therefore returns the programmed ticks value unchanged. It also reports lock (the period is stable) and overflow (no pulse arrived within the counter range).

Parameters:
N, 8, width of the tick counter and of ticks_out; matches the generator's N.
LOCK_COUNT, 2, number of consecutive identical measurements required to assert locked; legal range 1 to 15.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately.
ena  input  1  enable; when 0, all state holds and pulse_in is ignored.
pulse_in  input  1  strobe synchronous to clk; every cycle it is high counts as one pulse event (no edge detection).
ticks_out  output  N  last measured period, in cycles minus 1.
valid  output  1  one-cycle strobe; ticks_out was updated this cycle.
locked  output  1  period stable for LOCK_COUNT consecutive measurements.
overflow  output  1  high while in the OVERFLOW state.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, match_cnt=0.
  - ticks_out=0, valid=0, locked=0, overflow=0.
- All outputs are registered.
- valid asserts in the cycle after the clock edge on which the terminating pulse is sampled (1-cycle latency).
- ena=0:
  - No state, cnt or match_cnt change.
  - Pulses are ignored, valid=0, and other outputs hold.
  - Measurement resumes where it stopped, so a gap in ena stretches the measured period by design.
- Default each enabled cycle: valid<=0.
- IDLE:
  - pulse_in=1 -> MEASURE, cnt<=0.
  - No valid, because there is no prior reference pulse.
- MEASURE, pulse_in=1:
  - ticks_out<=cnt, valid<=1, cnt<=0.
  - Lock update: if cnt==ticks_out and a prior measurement exists, match_cnt<=sat(match_cnt+1); otherwise match_cnt<=1.
  - locked<=(next match_cnt >= LOCK_COUNT).
  - With LOCK_COUNT=1, locked asserts on the first valid measurement.
- MEASURE, pulse_in=0:
  - cnt != all-ones -> cnt<=cnt+1.
  - cnt == all-ones -> OVERFLOW, overflow<=1, locked<=0, match_cnt<=0.
  - cnt holds; there is no wrap.
- MEASURE boundaries:
  - Pulse arriving exactly when cnt==all-ones is a legal measurement: ticks_out=2^N-1, no overflow.
  - Back-to-back pulses (pulse_in high every cycle) measure ticks_out=0 each cycle, with valid high continuously.
- OVERFLOW:
  - pulse_in=1 -> MEASURE, cnt<=0, overflow<=0, no valid.
  - ticks_out keeps its last good value.
- Prior-measurement flag:
  - Cleared on reset and when entering OVERFLOW.
  - Set on the first valid measurement.
  - The first measurement after IDLE or OVERFLOW always sets match_cnt=1.
- match_cnt is 4 bits and saturates at 15.
- Width rules: cnt is N bits with unsigned compares; no arithmetic beyond +1.
- Reset mid-measurement: all state is abandoned immediately; the next pulse after release is treated as the first pulse (IDLE).

Decomposition:
- Shared package pulse_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_OVERFLOW} meter_state_t.
  - localparam MATCH_W=4.
- No sub-module is natural: the counter, FSM and lock tracker are small and tightly coupled. Implement flat in one always_ff plus next-state logic.

Test Plan:
- Reset then pulses at cycles 10, 16, 22 with N=8 -> no valid at 10; valid with ticks_out=5 after 16 and after 22; locked=1 after the second valid (LOCK_COUNT=2).
- Loopback from the pulse generator (ticks=3, ena=1) -> steady ticks_out=3, valid every 4 cycles, locked stays 1.
- Period change: gaps of 6, 6, then 9 cycles -> ticks_out 5, 5, then 8; locked goes 0->1 and drops to 0 on the 8; re-locks after the next 8.
- No pulse for 300 cycles after the first pulse (N=8) -> overflow=1 about 256 cycles after it and locked=0; the next pulse clears overflow without valid; the following 4-cycle gap gives ticks_out=3.
- pulse_in held high 5 cycles from IDLE -> valid on 4 consecutive cycles, ticks_out=0 each, locked=1 from the second.
- ena=0 for 3 cycles inside a 6-cycle gap -> ticks_out=2. Assert rst=0 mid-gap -> all outputs 0 asynchronously, the next pulse produces no valid.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types for the pulse period meter.
package pulse_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_OVERFLOW
  } meter_state_t;

  localparam int unsigned MATCH_W = 4;

endpackage

// File: rtl/pulse_period_meter.sv
// Measures the spacing between single-cycle strobes on pulse_in and reports it
// as "ticks" (period in clocks minus one), with lock and overflow indication.
module pulse_period_meter
  import pulse_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  output logic [N-1:0] ticks_out,
  output logic         valid,
  output logic         locked,
  output logic         overflow
);

  localparam logic [MATCH_W-1:0] LOCK_THR = MATCH_W'(LOCK_COUNT);

  meter_state_t       state_q, state_d;
  logic [N-1:0]       cnt_q, cnt_d;
  logic [N-1:0]       ticks_q, ticks_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               prior_q, prior_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               ovf_q, ovf_d;

  // Next-state: counter, FSM and lock tracker evaluated together
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ticks_d  = ticks_q;
    match_d  = match_q;
    prior_d  = prior_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (pulse_in) begin
            state_d = S_MEASURE;
            cnt_d   = '0;
          end
        end
        S_MEASURE: begin
          if (pulse_in) begin
            ticks_d = cnt_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            prior_d = 1'b1;
            if (prior_q && (cnt_q == ticks_q)) begin
              match_d = (match_q == '1) ? match_q : match_q + 1'b1;
            end else begin
              match_d = MATCH_W'(1);
            end
            locked_d = (match_d >= LOCK_THR);
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Counter pinned at all-ones: no wrap, lock history discarded
            state_d  = S_OVERFLOW;
            ovf_d    = 1'b1;
            locked_d = 1'b0;
            match_d  = '0;
            prior_d  = 1'b0;
          end
        end
        S_OVERFLOW: begin
          if (pulse_in) begin
            state_d = S_MEASURE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ticks_q  <= '0;
      match_q  <= '0;
      prior_q  <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ticks_q  <= ticks_d;
      match_q  <= match_d;
      prior_q  <= prior_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ticks_out = ticks_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (N=8, LOCK_COUNT=2).
module tb_pulse_period_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       pulse_in = 1'b0;
  logic [7:0] ticks_out;
  logic       valid;
  logic       locked;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_period_meter #(.N(8), .LOCK_COUNT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .pulse_in  (pulse_in),
    .ticks_out (ticks_out),
    .valid     (valid),
    .locked    (locked),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the active edge
  task automatic step(input logic p, input logic e);
    pulse_in = p;
    ena      = e;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         gap;
    logic       exp_valid;
    logic [7:0] exp_ticks;
    logic       exp_locked;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int spurious;
    int first_ovf;

    vecs[0]  = '{10,  1'b0, 8'd0,   1'b0};
    vecs[1]  = '{6,   1'b1, 8'd5,   1'b0};
    vecs[2]  = '{6,   1'b1, 8'd5,   1'b1};
    vecs[3]  = '{9,   1'b1, 8'd8,   1'b0};
    vecs[4]  = '{9,   1'b1, 8'd8,   1'b1};
    vecs[5]  = '{4,   1'b1, 8'd3,   1'b0};
    vecs[6]  = '{4,   1'b1, 8'd3,   1'b1};
    vecs[7]  = '{4,   1'b1, 8'd3,   1'b1};
    vecs[8]  = '{1,   1'b1, 8'd0,   1'b0};
    vecs[9]  = '{1,   1'b1, 8'd0,   1'b1};
    vecs[10] = '{256, 1'b1, 8'd255, 1'b0};
    vecs[11] = '{256, 1'b1, 8'd255, 1'b1};

    // Reset state
    #2 rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("rst_ticks", 32'(ticks_out), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_overflow", 32'(overflow), 0);
    #3 rst = 1'b1;

    // Table of pulse gaps measured in clock cycles
    for (int i = 0; i < 12; i++) begin
      spurious = 0;
      for (int k = 1; k < vecs[i].gap; k++) begin
        step(1'b0, 1'b1);
        if (valid !== 1'b0) spurious++;
      end
      step(1'b1, 1'b1);
      check($sformatf("vec%0d_gap_valid", i), 32'(spurious), 0);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ticks", i), 32'(ticks_out), 32'(vecs[i].exp_ticks));
      check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].exp_locked));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 0);
    end

    // Overflow: 300 silent cycles after a pulse
    first_ovf = -1;
    for (int j = 1; j <= 300; j++) begin
      step(1'b0, 1'b1);
      if (overflow === 1'b1 && first_ovf < 0) first_ovf = j;
    end
    check("ovf_first_cycle", 32'(first_ovf), 256);
    check("ovf_held", 32'(overflow), 1);
    check("ovf_locked", 32'(locked), 0);
    check("ovf_ticks_kept", 32'(ticks_out), 255);
    step(1'b1, 1'b1);
    check("ovf_exit_overflow", 32'(overflow), 0);
    check("ovf_exit_valid", 32'(valid), 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("ovf_after_valid", 32'(valid), 1);
    check("ovf_after_ticks", 32'(ticks_out), 3);
    check("ovf_after_locked", 32'(locked), 0);

    // Enable gap: 3 of the 5 idle cycles disabled, one carrying an ignored pulse
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("ena_pulse_ignored", 32'(valid), 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("ena_ticks_hold", 32'(ticks_out), 3);
    step(1'b1, 1'b1);
    check("ena_valid", 32'(valid), 1);
    check("ena_ticks", 32'(ticks_out), 2);

    // Same gap again to get locked before the reset test
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("relock_ticks", 32'(ticks_out), 2);
    check("relock_locked", 32'(locked), 1);

    // Asynchronous reset mid-gap
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("arst_ticks", 32'(ticks_out), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_valid", 32'(valid), 0);
    step(1'b0, 1'b1);
    #3 rst = 1'b1;

    // pulse_in held high five cycles from IDLE
    step(1'b1, 1'b1);
    check("hold_first_valid", 32'(valid), 0);
    for (int j = 2; j <= 5; j++) begin
      step(1'b1, 1'b1);
      check($sformatf("hold%0d_valid", j), 32'(valid), 1);
      check($sformatf("hold%0d_ticks", j), 32'(ticks_out), 0);
      check($sformatf("hold%0d_locked", j), 32'(locked), (j >= 3) ? 1 : 0);
    end
    step(1'b0, 1'b1);
    check("hold_end_valid", 32'(valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
